// File: rtl/urv_divide_if.sv
// urv_divide_if: request/response bundle between the execute stage and the
// RV32M divider.
//   d_start_i  start strobe (sampled by the divider only while idle)
//   d_rs1_i    dividend
//   d_rs2_i    divisor
//   d_fun_i    funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU
//   x_kill_i   abort the operation in flight
//   x_busy_o   operation in flight (stall request)
//   w_valid_o  one-cycle pulse, w_rd_o valid
//   w_rd_o     quotient or remainder
// master = pipeline side, slave = divider side.
interface urv_divide_if;
  logic        d_start_i;
  logic [31:0] d_rs1_i;
  logic [31:0] d_rs2_i;
  logic [2:0]  d_fun_i;
  logic        x_kill_i;
  logic        x_busy_o;
  logic        w_valid_o;
  logic [31:0] w_rd_o;

  modport master (
    output d_start_i, d_rs1_i, d_rs2_i, d_fun_i, x_kill_i,
    input  x_busy_o, w_valid_o, w_rd_o
  );

  modport slave (
    input  d_start_i, d_rs1_i, d_rs2_i, d_fun_i, x_kill_i,
    output x_busy_o, w_valid_o, w_rd_o
  );
endinterface

// File: rtl/urv_divide.sv
// urv_divide: multi-cycle RV32M divider (DIV/DIVU/REM/REMU).
// Restoring shift-subtract on operand magnitudes, one quotient bit per
// cycle, followed by a sign-correction cycle.
// Ports:
//   clk_i  clock, rising edge
//   rst_i  asynchronous active-high reset
//   bus    urv_divide_if.slave (start/operands/kill in, busy/valid/result out)
// Optional build macro URV_DIV_FAST_PATH_EN: divide-by-zero and signed
// overflow complete directly from IDLE to DONE at the start edge.
module urv_divide (
  input logic          clk_i,
  input logic          rst_i,
  urv_divide_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state;
  logic [5:0]  count;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] dvs;
  logic [31:0] result;
  logic        rem_sel;
  logic        neg_q;
  logic        neg_r;

  logic        in_signed;
  logic [31:0] rs1_mag;
  logic [31:0] rs2_mag;
  logic [32:0] rem_sh;
  logic        fits;
  logic [31:0] rem_sub;
  logic [31:0] fix_res;

  always_comb begin
    in_signed = ~bus.d_fun_i[0];
    // Negating 0x80000000 yields 0x80000000, which is the correct unsigned
    // magnitude, so no extra datapath bit is needed.
    rs1_mag   = (in_signed && bus.d_rs1_i[31]) ? (~bus.d_rs1_i + 32'd1) : bus.d_rs1_i;
    rs2_mag   = (in_signed && bus.d_rs2_i[31]) ? (~bus.d_rs2_i + 32'd1) : bus.d_rs2_i;
    rem_sh    = {rem, quo[31]};
    fits      = (rem_sh >= {1'b0, dvs});
    // When fits, the difference is below dvs, so 32-bit wraparound is exact.
    rem_sub   = rem_sh[31:0] - dvs;
    fix_res   = rem_sel ? (neg_r ? (~rem + 32'd1) : rem)
                        : (neg_q ? (~quo + 32'd1) : quo);
  end

`ifdef URV_DIV_FAST_PATH_EN
  logic        fast_hit;
  logic [31:0] fast_res;

  always_comb begin
    fast_hit = (bus.d_rs2_i == '0) ||
               (in_signed && bus.d_rs1_i == 32'h8000_0000 && bus.d_rs2_i == '1);
    if (bus.d_rs2_i == '0)
      fast_res = bus.d_fun_i[1] ? bus.d_rs1_i : '1;
    else
      fast_res = bus.d_fun_i[1] ? '0 : 32'h8000_0000;
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= S_IDLE;
      count   <= '0;
      quo     <= '0;
      rem     <= '0;
      dvs     <= '0;
      result  <= '0;
      rem_sel <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else if (bus.x_kill_i) begin
      state <= S_IDLE;
      count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.d_start_i) begin
            quo     <= rs1_mag;
            rem     <= '0;
            dvs     <= rs2_mag;
            count   <= '0;
            rem_sel <= bus.d_fun_i[1];
            // A zero divisor must leave the all-ones quotient uncorrected;
            // the remainder sign rule already reproduces rs1.
            neg_q   <= in_signed && (bus.d_rs1_i[31] ^ bus.d_rs2_i[31]) &&
                       (bus.d_rs2_i != '0);
            neg_r   <= in_signed && bus.d_rs1_i[31];
`ifdef URV_DIV_FAST_PATH_EN
            if (fast_hit) begin
              result <= fast_res;
              state  <= S_DONE;
            end else
`endif
              state <= S_BUSY;
          end
        end
        S_BUSY: begin
          // Iterations run while count is 0..31; count reaching 32 means
          // all quotient bits are in and the next edge moves to FIX.
          if (count == 6'd32) begin
            state <= S_FIX;
          end else begin
            count <= count + 6'd1;
            rem   <= fits ? rem_sub : rem_sh[31:0];
            quo   <= {quo[30:0], fits};
          end
        end
        S_FIX: begin
          result <= fix_res;
          state  <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.x_busy_o  = (state != S_IDLE);
  assign bus.w_valid_o = (state == S_DONE);
  assign bus.w_rd_o    = result;

endmodule

// File: doc/urv_divide.md
URV_DIVIDE -- requirements
Module: urv_divide

Interface
REQ-001 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port d_start_i  input  1  start strobe, sampled only in IDLE.
REQ-004 SHALL have port d_rs1_i  input  32  dividend.
REQ-005 SHALL have port d_rs2_i  input  32  divisor.
REQ-006 SHALL have port d_fun_i  input  3  RV32M funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have port x_kill_i  input  1  abort current operation.
REQ-008 SHALL have port x_busy_o  output  1  high while an operation is in flight (pipeline stall request).
REQ-009 SHALL have port w_valid_o  output  1  one-cycle pulse marking w_rd_o valid.
REQ-010 SHALL have port w_rd_o  output  32  quotient or remainder per d_fun_i.

Function
REQ-011 SHALL implement states IDLE, BUSY, FIX and DONE.
REQ-012 SHALL register d_rs1_i, d_rs2_i and d_fun_i on the edge where d_start_i=1 in IDLE; later input changes SHALL NOT affect the result.
REQ-013 SHALL, for signed ops (funct3[0]=0), divide magnitudes and record sign(quotient)=sign(rs1) XOR sign(rs2) and sign(remainder)=sign(rs1).
REQ-014 SHALL run BUSY as a 32-iteration restoring shift-subtract loop, one quotient bit per cycle, with a 6-bit counter that counts 0..31.
REQ-015 SHALL leave BUSY for FIX after the 32nd iteration; FIX SHALL apply two's-complement sign correction and then go to DONE.
REQ-016 SHALL assert w_valid_o for exactly one cycle in DONE and return to IDLE on the next edge.
REQ-017 SHALL give normal latency as follows: start edge = edge 0; w_valid_o high in the cycle following edge 34.
REQ-018 SHALL hold w_rd_o stable from DONE until the next accepted start.
REQ-019 SHALL drive x_busy_o high from the cycle after the start edge through the DONE cycle inclusive.
REQ-020 SHALL ignore d_start_i when not in IDLE.
REQ-021 SHALL produce the following for divisor=0: DIV/DIVU quotient 0xFFFFFFFF; REM/REMU remainder = rs1 unchanged.
REQ-022 SHALL produce the following for signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
REQ-023 SHALL compute magnitude of 0x80000000 as unsigned 0x80000000, with no overflow in the datapath.
REQ-024 SHALL return to IDLE on the next edge when x_kill_i=1 in any state, with no w_valid_o pulse.
REQ-025 SHALL let x_kill_i win over d_start_i when both are asserted in the same IDLE cycle; the start is dropped.
REQ-026 SHALL accept a new start on the first IDLE cycle after DONE or after a kill.

Reset
REQ-027 SHALL, while rst_i is asserted, immediately force state=IDLE, counter=0, x_busy_o=0, w_valid_o=0 and w_rd_o=0, regardless of clk_i.
REQ-028 SHALL, if reset is asserted mid-operation, discard the operation with no w_valid_o pulse after reset release.
REQ-029 SHALL reset all internal datapath registers to zero.

Configuration
REQ-030 SHALL, when URV_DIV_FAST_PATH_EN is defined, detect divisor=0 and signed overflow at the start edge, go directly IDLE->DONE with the REQ-021/022 result, and pulse w_valid_o in the cycle after the start edge (latency 1).
REQ-031 SHALL, when URV_DIV_FAST_PATH_EN is undefined, run the full BUSY/FIX sequence for these cases; results SHALL be identical to the fast path and only latency SHALL differ (REQ-017).
REQ-032 SHALL keep latency for all other operands unaffected by URV_DIV_FAST_PATH_EN.

Verification
REQ-033 SHALL verify DIVU: rs1=100, rs2=7 -> w_rd_o=14, w_valid_o one cycle after edge 34; REMU with the same operands -> 2.
REQ-034 SHALL verify signed DIV/REM: rs1=-7 (0xFFFFFFF9), rs2=2 -> DIV 0xFFFFFFFD (-3), REM 0xFFFFFFFF (-1).
REQ-035 SHALL verify divide-by-zero: rs1=0x12345678, rs2=0 -> DIV 0xFFFFFFFF, REMU 0x12345678; latency 1 with URV_DIV_FAST_PATH_EN, else 34.
REQ-036 SHALL verify signed overflow: rs1=0x80000000, rs2=0xFFFFFFFF -> DIV 0x80000000, REM 0x00000000.
REQ-037 SHALL verify abort: x_kill_i at iteration 10 -> IDLE next cycle, no w_valid_o; an immediately following DIVU 9/3 -> 3 at normal latency.
REQ-038 SHALL verify reset and ignored start: rst_i pulsed mid-BUSY (asynchronous, between clock edges) -> outputs 0 at once, no pulse; d_start_i asserted during BUSY -> ignored and result unchanged.
